// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one line-wide backing memory between the I-cache and D-cache.
// Grants one port at a time, forwards its request downstream and routes mem_ready back to it.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 27,
  parameter int unsigned LINE_W = 256
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [LINE_W-1:0] i_mem_wdata,
  output logic [LINE_W-1:0] i_mem_rdata,
  output logic              i_mem_ready,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_addr,
  input  logic [LINE_W-1:0] d_mem_wdata,
  output logic [LINE_W-1:0] d_mem_rdata,
  output logic              d_mem_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              arb_err
);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;

  state_t state;
  logic   last;  // 0: I-cache was granted most recently, 1: D-cache
  logic   req_i;
  logic   req_d;

  assign req_i = i_mem_read | i_mem_write;
  assign req_d = d_mem_read | d_mem_write;

  assign i_mem_rdata = mem_rdata;
  assign d_mem_rdata = mem_rdata;

  // Grant sequencing, round-robin history and sticky protocol-error flag.
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state   <= IDLE;
      last    <= 1'b0;
      arb_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_ready) arb_err <= 1'b1;
          if (req_i && req_d) state <= last ? GRANT_I : GRANT_D;
          else if (req_i)     state <= GRANT_I;
          else if (req_d)     state <= GRANT_D;
        end
        GRANT_I: begin
          if (i_mem_read && i_mem_write) arb_err <= 1'b1;
          if (mem_ready) begin
            state <= IDLE;
            last  <= 1'b0;
          end else if (!req_i) begin
            arb_err <= 1'b1;
          end
        end
        GRANT_D: begin
          if (d_mem_read && d_mem_write) arb_err <= 1'b1;
          if (mem_ready) begin
            state <= IDLE;
            last  <= 1'b1;
          end else if (!req_d) begin
            arb_err <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Downstream request mux and ready routing; a read+write request forwards only the write.
  always_comb begin
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    i_mem_ready = 1'b0;
    d_mem_ready = 1'b0;
    case (state)
      GRANT_I: begin
        mem_read    = i_mem_read & ~i_mem_write;
        mem_write   = i_mem_write;
        mem_addr    = i_mem_addr;
        mem_wdata   = i_mem_wdata;
        i_mem_ready = mem_ready;
      end
      GRANT_D: begin
        mem_read    = d_mem_read & ~d_mem_write;
        mem_write   = d_mem_write;
        mem_addr    = d_mem_addr;
        mem_wdata   = d_mem_wdata;
        d_mem_ready = mem_ready;
      end
      default: ;
    endcase
  end

endmodule
